// File: rtl/act_feeder_pkg.sv
// act_feeder_pkg
//   Shared definitions for the activation feeder: pack-state encoding and
//   default sizing constants used by act_feeder and act_feeder_fifo.
package act_feeder_pkg;

  localparam int WID_ACT_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  // LOW: no element held; HIGH: low half of the next word sits in the hold register.
  typedef enum logic [0:0] {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } pack_state_e;

endpackage

// File: rtl/act_feeder_fifo.sv
// act_feeder_fifo
//   Synchronous FIFO of packed activation words with a registered head.
//   Ports:
//     clk_l     - clock (rising edge)
//     rst       - synchronous active-high reset
//     clr       - synchronous flush, dominates push/pop
//     push/din  - write request / data (ignored while full)
//     pop       - read request (ignored while empty)
//     full      - occupancy == DEPTH
//     empty     - occupancy == 0
//     cnt       - occupancy in words, 0..DEPTH
//     head      - registered head-of-queue word
//     head_vld  - registered, high while the FIFO holds at least one word
module act_feeder_fifo
  import act_feeder_pkg::*;
#(
  parameter int WID     = 2 * WID_ACT_DEF,
  parameter int DEPTH   = FIFO_DEPTH_DEF,
  parameter int WID_CNT = $clog2(DEPTH) + 1
) (
  input  logic               clk_l,
  input  logic               rst,
  input  logic               clr,
  input  logic               push,
  input  logic [WID-1:0]     din,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [WID_CNT-1:0] cnt,
  output logic [WID-1:0]     head,
  output logic               head_vld
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WID-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_nxt_s;
  logic [WID_CNT-1:0] cnt_r;
  logic [WID_CNT-1:0] cnt_nxt_s;
  logic [WID-1:0]     head_r;
  logic [WID-1:0]     head_nxt_s;
  logic               head_vld_r;
  logic               push_s;
  logic               pop_s;

  assign full         = (cnt_r == WID_CNT'(DEPTH));
  assign empty        = (cnt_r == {WID_CNT{1'b0}});
  assign push_s       = push & ~full;
  assign pop_s        = pop & ~empty;
  assign rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1'b1);

  assign cnt      = cnt_r;
  assign head     = head_r;
  assign head_vld = head_vld_r;

  // Next occupancy and next head word. The head register is preloaded so the
  // output never depends combinationally on the storage read.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    head_nxt_s = head_r;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + WID_CNT'(1'b1);
      2'b01:   cnt_nxt_s = cnt_r - WID_CNT'(1'b1);
      default: cnt_nxt_s = cnt_r;
    endcase
    if (pop_s) begin
      if (cnt_r == WID_CNT'(1'b1)) begin
        // Last word leaves; a same-cycle push becomes the new head directly.
        if (push_s) begin
          head_nxt_s = din;
        end else begin
          head_nxt_s = head_r;
        end
      end else begin
        head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
    end else if (push_s && empty) begin
      head_nxt_s = din;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Pointer, occupancy and head registers; clr flushes like reset.
  always_ff @(posedge clk_l) begin
    if (rst || clr) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      cnt_r      <= {WID_CNT{1'b0}};
      head_r     <= {WID{1'b0}};
      head_vld_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_nxt_s;
      end
      cnt_r      <= cnt_nxt_s;
      head_r     <= head_nxt_s;
      head_vld_r <= (cnt_nxt_s != {WID_CNT{1'b0}});
    end
  end

  // Storage array; contents are don't-care until a pointer reaches them.
  always_ff @(posedge clk_l) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

endmodule

// File: rtl/act_feeder.sv
// act_feeder
//   Packs pairs of activation elements into double-width words and queues
//   them for a superblock row. The earlier element lands in the low half.
//   Optional build macro: ACT_FEEDER_ZPAD_EN - an element accepted with
//   s_last while no half is held is pushed immediately zero-padded.
//   Ports:
//     clk_l, rst, clr              - clock, sync active-high reset, sync flush
//     s_data/s_vld/s_last/s_rdy    - upstream element stream
//     act_data_in/_vld/_req        - packed word stream to the row
//     fifo_cnt                     - FIFO occupancy in packed words
//     busy                         - FIFO non-empty or half-word held
module act_feeder
  import act_feeder_pkg::*;
#(
  parameter int WID_ACT    = WID_ACT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int WID_CNT    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk_l,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [WID_ACT-1:0]   s_data,
  input  logic                 s_vld,
  input  logic                 s_last,
  output logic                 s_rdy,
  output logic [2*WID_ACT-1:0] act_data_in,
  output logic                 act_data_in_vld,
  input  logic                 act_data_in_req,
  output logic [WID_CNT-1:0]   fifo_cnt,
  output logic                 busy
);

  pack_state_e          state_r;
  pack_state_e          state_nxt_s;
  logic [WID_ACT-1:0]   hold_r;
  logic [WID_ACT-1:0]   hold_nxt_s;
  logic                 push_s;
  logic [2*WID_ACT-1:0] push_data_s;
  logic                 full_s;
  logic                 empty_s;
  logic                 accept_s;
  logic                 pop_s;

`ifdef ACT_FEEDER_ZPAD_EN
  // A frame tail in LOW writes the FIFO, so it also needs a free slot.
  assign s_rdy = ~full_s | ((state_r == ST_LOW) & ~s_last);
`else
  logic last_unused_s;
  assign last_unused_s = s_last;
  assign s_rdy = (state_r == ST_LOW) | ~full_s;
`endif

  assign accept_s = s_vld & s_rdy;
  assign pop_s    = act_data_in_vld & act_data_in_req;
  assign busy     = ~empty_s | (state_r == ST_HIGH);

  // Pack FSM: next state, hold register and FIFO write.
  always_comb begin
    state_nxt_s = state_r;
    hold_nxt_s  = hold_r;
    push_s      = 1'b0;
    push_data_s = {(2 * WID_ACT){1'b0}};
    case (state_r)
      ST_LOW: begin
        if (accept_s) begin
`ifdef ACT_FEEDER_ZPAD_EN
          if (s_last) begin
            push_s      = 1'b1;
            push_data_s = {{WID_ACT{1'b0}}, s_data};
          end else begin
            hold_nxt_s  = s_data;
            state_nxt_s = ST_HIGH;
          end
`else
          hold_nxt_s  = s_data;
          state_nxt_s = ST_HIGH;
`endif
        end else begin
          state_nxt_s = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (accept_s) begin
          push_s      = 1'b1;
          push_data_s = {s_data, hold_r};
          state_nxt_s = ST_LOW;
        end else begin
          state_nxt_s = ST_HIGH;
        end
      end
      default: begin
        state_nxt_s = ST_LOW;
      end
    endcase
  end

  // Pack state and hold register; clr discards any held half.
  always_ff @(posedge clk_l) begin
    if (rst || clr) begin
      state_r <= ST_LOW;
      hold_r  <= {WID_ACT{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      hold_r  <= hold_nxt_s;
    end
  end

  act_feeder_fifo #(
    .WID     (2 * WID_ACT),
    .DEPTH   (FIFO_DEPTH),
    .WID_CNT (WID_CNT)
  ) u_fifo (
    .clk_l    (clk_l),
    .rst      (rst),
    .clr      (clr),
    .push     (push_s),
    .din      (push_data_s),
    .pop      (pop_s),
    .full     (full_s),
    .empty    (empty_s),
    .cnt      (fifo_cnt),
    .head     (act_data_in),
    .head_vld (act_data_in_vld)
  );

endmodule

// File: tb/tb_act_feeder.sv
// tb_act_feeder
//   Directed self-checking bench for act_feeder (default parameters).
//   Inputs change 1 ns after the rising edge; outputs are sampled there too.
//   Words handed to the row are captured on the falling edge.
module tb_act_feeder;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk_l = 1'b0;
  logic          rst;
  logic          clr;
  logic [W-1:0]  s_data;
  logic          s_vld;
  logic          s_last;
  logic          s_rdy;
  logic [2*W-1:0] act_data_in;
  logic          act_data_in_vld;
  logic          act_data_in_req;
  logic [CW-1:0] fifo_cnt;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] got_q[$];

  always #5 clk_l = ~clk_l;

  act_feeder #(.WID_ACT(W), .FIFO_DEPTH(D), .WID_CNT(CW)) dut (
    .clk_l           (clk_l),
    .rst             (rst),
    .clr             (clr),
    .s_data          (s_data),
    .s_vld           (s_vld),
    .s_last          (s_last),
    .s_rdy           (s_rdy),
    .act_data_in     (act_data_in),
    .act_data_in_vld (act_data_in_vld),
    .act_data_in_req (act_data_in_req),
    .fifo_cnt        (fifo_cnt),
    .busy            (busy)
  );

  // Capture every word that transfers on the coming rising edge.
  always @(negedge clk_l) begin
    if (!rst && !clr && act_data_in_vld && act_data_in_req)
      got_q.push_back(act_data_in);
  end

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  // Offer one element and hold it until accepted (bounded wait).
  task automatic send(input logic [W-1:0] d, input logic last);
    s_vld  = 1'b1;
    s_data = d;
    s_last = last;
    for (int i = 0; i < 50 && s_rdy !== 1'b1; i++) tick();
    n_checks++;
    if (s_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: s_rdy=%b required 1 for element %h", s_rdy, d);
    end
    tick();
    s_vld  = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; s_vld = 1'b0; s_data = '0; s_last = 1'b0;
    act_data_in_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_checks++; if (act_data_in_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b required 0", act_data_in_vld); end
    n_checks++; if (act_data_in !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h required 00000000", act_data_in); end
    n_checks++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", fifo_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_checks++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b required 1", s_rdy); end
  endtask

  task automatic test_basic();
    got_q.delete();
    act_data_in_req = 1'b1;
    send(16'h0001, 1'b0);
    n_checks++; if (act_data_in_vld !== 1'b0) begin n_fail++; $display("FAIL basic_vld_half: got %b required 0", act_data_in_vld); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_half: got %b required 1", busy); end
    send(16'h0002, 1'b0);
    n_checks++; if (act_data_in_vld !== 1'b1) begin n_fail++; $display("FAIL basic_latency_vld: got %b required 1", act_data_in_vld); end
    n_checks++; if (act_data_in !== 32'h00020001) begin n_fail++; $display("FAIL basic_latency_data: got %h required 00020001", act_data_in); end
    send(16'h0003, 1'b0);
    send(16'h0004, 1'b0);
    repeat (3) tick();
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL basic_count: got %0d words required 2", got_q.size()); end
    n_checks++; if (got_q[0] !== 32'h00020001) begin n_fail++; $display("FAIL basic_word0: got %h required 00020001", got_q[0]); end
    n_checks++; if (got_q[1] !== 32'h00040003) begin n_fail++; $display("FAIL basic_word1: got %h required 00040003", got_q[1]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: busy %b required 0", busy); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic go;
    logic [2*W-1:0] exp_w [5] = '{32'h00020001, 32'h00040003, 32'h00060005,
                                  32'h00080007, 32'h000A0009};
    got_q.delete();
    act_data_in_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (acc < 10) begin s_vld = 1'b1; s_data = 16'(acc + 1); end
      else s_vld = 1'b0;
      go = s_vld & s_rdy;
      tick();
      if (go) acc++;
    end
    n_checks++; if (acc !== 9) begin n_fail++; $display("FAIL bp_accepted: got %0d elements required 9", acc); end
    n_checks++; if (fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL bp_cnt_full: got %0d required 4", fifo_cnt); end
    n_checks++; if (s_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy_full: got %b required 0", s_rdy); end
    n_checks++; if (act_data_in !== 32'h00020001) begin n_fail++; $display("FAIL bp_head_stable: got %h required 00020001", act_data_in); end
    act_data_in_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (acc < 10) begin s_vld = 1'b1; s_data = 16'(acc + 1); end
      else s_vld = 1'b0;
      go = s_vld & s_rdy;
      tick();
      if (go) acc++;
    end
    s_vld = 1'b0;
    n_checks++; if (got_q.size() !== 5) begin n_fail++; $display("FAIL bp_count: got %0d words required 5", got_q.size()); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (got_q[i] !== exp_w[i]) begin n_fail++; $display("FAIL bp_word%0d: got %h required %h", i, got_q[i], exp_w[i]); end
    end
    n_checks++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL bp_drained: cnt %0d required 0", fifo_cnt); end
  endtask

  task automatic test_wrap();
    logic [2*W-1:0] exp_w;
    got_q.delete();
    act_data_in_req = 1'b0;
    for (int i = 0; i < 4; i++) send(16'h0100 + 16'(i), 1'b0);
    n_checks++; if (fifo_cnt !== 3'd2) begin n_fail++; $display("FAIL wrap_prefill: cnt %0d required 2", fifo_cnt); end
    // Pop only on the cycle a word is pushed, so occupancy must hold at 2.
    for (int j = 2; j < 20; j++) begin
      act_data_in_req = 1'b0;
      send(16'h0100 + 16'(2 * j), 1'b0);
      act_data_in_req = 1'b1;
      send(16'h0100 + 16'(2 * j + 1), 1'b0);
      n_checks++;
      if (fifo_cnt !== 3'd2) begin n_fail++; $display("FAIL wrap_cnt_%0d: got %0d required 2", j, fifo_cnt); end
    end
    repeat (6) tick();
    n_checks++; if (got_q.size() !== 20) begin n_fail++; $display("FAIL wrap_count: got %0d words required 20", got_q.size()); end
    for (int j = 0; j < 20; j++) begin
      exp_w = {16'h0100 + 16'(2 * j + 1), 16'h0100 + 16'(2 * j)};
      n_checks++;
      if (got_q[j] !== exp_w) begin n_fail++; $display("FAIL wrap_word%0d: got %h required %h", j, got_q[j], exp_w); end
    end
  endtask

  task automatic test_zpad();
    got_q.delete();
    act_data_in_req = 1'b1;
    send(16'h00AA, 1'b0);
    send(16'h00BB, 1'b0);
    send(16'h00CC, 1'b1);
    repeat (4) tick();
`ifdef ACT_FEEDER_ZPAD_EN
    n_checks++; if (got_q.size() !== 2) begin n_fail++; $display("FAIL zpad_count: got %0d words required 2", got_q.size()); end
    n_checks++; if (got_q[0] !== 32'h00BB00AA) begin n_fail++; $display("FAIL zpad_word0: got %h required 00BB00AA", got_q[0]); end
    n_checks++; if (got_q[1] !== 32'h000000CC) begin n_fail++; $display("FAIL zpad_word1: got %h required 000000CC", got_q[1]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zpad_busy: got %b required 0", busy); end
    send(16'h00DD, 1'b1);
    repeat (4) tick();
    n_checks++; if (got_q[2] !== 32'h000000DD) begin n_fail++; $display("FAIL zpad_word2: got %h required 000000DD", got_q[2]); end
`else
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL tail_count: got %0d words required 1", got_q.size()); end
    n_checks++; if (got_q[0] !== 32'h00BB00AA) begin n_fail++; $display("FAIL tail_word0: got %h required 00BB00AA", got_q[0]); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tail_held_busy: got %b required 1", busy); end
    send(16'h00DD, 1'b0);
    repeat (4) tick();
    n_checks++; if (got_q[1] !== 32'h00DD00CC) begin n_fail++; $display("FAIL tail_word1: got %h required 00DD00CC", got_q[1]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tail_idle: busy %b required 0", busy); end
`endif
  endtask

  task automatic test_clr();
    act_data_in_req = 1'b0;
    for (int i = 0; i < 7; i++) send(16'h0041 + 16'(i), 1'b0);
    n_checks++; if (fifo_cnt !== 3'd3) begin n_fail++; $display("FAIL clr_prefill: cnt %0d required 3", fifo_cnt); end
    s_vld = 1'b1; s_data = 16'h0BAD; clr = 1'b1;
    tick();
    clr = 1'b0; s_vld = 1'b0;
    n_checks++; if (act_data_in_vld !== 1'b0) begin n_fail++; $display("FAIL clr_vld: got %b required 0", act_data_in_vld); end
    n_checks++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d required 0", fifo_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_busy: got %b required 0", busy); end
    n_checks++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL clr_rdy: got %b required 1", s_rdy); end
    got_q.delete();
    act_data_in_req = 1'b1;
    send(16'h0011, 1'b0);
    send(16'h0022, 1'b0);
    repeat (4) tick();
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL clr_after_count: got %0d words required 1", got_q.size()); end
    n_checks++; if (got_q[0] !== 32'h00220011) begin n_fail++; $display("FAIL clr_after_word: got %h required 00220011", got_q[0]); end
  endtask

  task automatic test_rst_midstream();
    act_data_in_req = 1'b0;
    send(16'h0031, 1'b0);
    send(16'h0032, 1'b0);
    send(16'h0033, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (act_data_in_vld !== 1'b0) begin n_fail++; $display("FAIL rst_vld: got %b required 0", act_data_in_vld); end
    n_checks++; if (act_data_in !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h required 00000000", act_data_in); end
    n_checks++; if (fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d required 0", fifo_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy); end
    n_checks++; if (s_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rdy: got %b required 1", s_rdy); end
    got_q.delete();
    act_data_in_req = 1'b1;
    send(16'h0005, 1'b0);
    send(16'h0006, 1'b0);
    repeat (4) tick();
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL rst_after_count: got %0d words required 1", got_q.size()); end
    n_checks++; if (got_q[0] !== 32'h00060005) begin n_fail++; $display("FAIL rst_after_word: got %h required 00060005", got_q[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zpad();
    test_clr();
    test_rst_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/act_feeder.md
ACT_FEEDER -- requirements
Module: act_feeder

Interface
REQ-001 Parameter WID_ACT, default 16, activation element width.
REQ-002 Parameter FIFO_DEPTH, default 4, packed-word FIFO entries; power of 2, >= 2.
REQ-003 Parameter WID_CNT, default $clog2(FIFO_DEPTH)+1, occupancy counter width.
REQ-004 clk_l  input  1  sole clock, all logic on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 clr  input  1  synchronous flush of FIFO and pack state.
REQ-007 s_data  input  WID_ACT  upstream activation element.
REQ-008 s_vld  input  1  s_data valid.
REQ-009 s_last  input  1  marks last element of a frame; qualified by s_vld.
REQ-010 s_rdy  output  1  element accepted when s_vld & s_rdy.
REQ-011 act_data_in  output  2*WID_ACT  packed word to superblock row; [WID_ACT-1:0] = earlier element.
REQ-012 act_data_in_vld  output  1  act_data_in valid.
REQ-013 act_data_in_req  input  1  row requests data; word transfers when act_data_in_vld & act_data_in_req.
REQ-014 fifo_cnt  output  WID_CNT  FIFO occupancy in packed words.
REQ-015 busy  output  1  high when FIFO non-empty or half-word held.

Function
REQ-016 Pack FSM states: LOW (no element held), HIGH (low half held in hold register).
REQ-017 LOW + accept: store s_data in hold register, go HIGH; no FIFO write.
REQ-018 HIGH + accept: push {s_data, hold} to FIFO, go LOW.
REQ-019 s_rdy = (state==LOW) | ~FIFO full; no combinational path from act_data_in_req to s_rdy.
REQ-020 FIFO head drives act_data_in / act_data_in_vld registered; act_data_in_vld = FIFO non-empty.
REQ-021 Latency: word visible on act_data_in the cycle after its high half is accepted, if FIFO was empty.
REQ-022 Pop on act_data_in_vld & act_data_in_req; head advances next cycle; act_data_in held stable while vld & ~req.
REQ-023 Simultaneous push and pop: fifo_cnt unchanged, order preserved.
REQ-024 Pointers wrap modulo FIFO_DEPTH; fifo_cnt ranges 0..FIFO_DEPTH, never overflows or underflows.
REQ-025 act_data_in_req while empty: ignored, no state change.
REQ-026 clr: next cycle FIFO empty, FSM LOW, hold cleared; inputs in clr cycle discarded; clr dominates push/pop.
REQ-027 s_last in HIGH: normal pack. s_last in LOW: per REQ-031/REQ-032.

Reset
REQ-028 rst: state LOW, hold=0, pointers=0, fifo_cnt=0, act_data_in_vld=0, act_data_in=0, busy=0, s_rdy=1 from the first cycle after release.
REQ-029 rst mid-frame: partial half and all FIFO contents discarded, no word emitted.
REQ-030 FIFO storage array needs no reset; outputs masked by reset values.

Configuration
REQ-031 ACT_FEEDER_ZPAD_EN defined: accept with s_last in LOW pushes {0, s_data} immediately, FSM stays LOW.
REQ-032 ACT_FEEDER_ZPAD_EN undefined: s_last ignored; odd tail element stays held and pairs with next frame's first element; s_rdy in LOW always 1.

Structure
REQ-033 Shared package act_feeder_pkg: pack-state enum (LOW, HIGH), default WID_ACT / FIFO_DEPTH constants.
REQ-034 One sub-module act_feeder_fifo: synchronous FIFO, push/pop/full/empty/cnt, registered head output.

Verification
REQ-035 Elements 0x0001,0x0002,0x0003,0x0004, req=1 -> words 0x00020001 then 0x00040003, first vld 1 cycle after 0x0002 accepted.
REQ-036 req=0, 10 elements streamed -> fifo_cnt reaches 4, s_rdy low in HIGH with 9th held; req=1 drains 4 words in order then 5th word 0x..., no loss.
REQ-037 ZPAD_EN, elements 0x00AA,0x00BB,0x00CC(s_last) -> 0x00BB00AA then 0x000000CC; undefined -> 0x00CC held, next 0x00DD gives 0x00DD00CC.
REQ-038 FIFO at cnt=2, push and pop same cycle -> cnt stays 2, output order correct across pointer wrap (20 words continuous).
REQ-039 clr asserted with 3 words queued and HIGH held, s_vld=1 same cycle -> next cycle vld=0, cnt=0, busy=0, state LOW, element discarded.
REQ-040 rst asserted mid-stream for 1 cycle -> all outputs at REQ-028 values next cycle; subsequent 0x0005,0x0006 yields 0x00060005.
